// File: rtl/imem_boot_loader_if.sv
// Byte-stream receive channel and instruction-memory write port of the boot loader.
// The slave modport is the loader's view; master is the host/memory side.
interface imem_boot_loader_if #(
    parameter int unsigned ADDR_W = 6
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [31:0]       im_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, im_we, im_waddr, im_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, im_we, im_waddr, im_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot sequencer: loads a length-prefixed byte stream into instruction memory,
// releases the core, counts cycles until the halt instruction and parks the core.
module imem_boot_loader #(
    parameter int unsigned N          = 64,
    parameter int unsigned ADDR_W     = 6,
    parameter logic [31:0] HALT_INSTR = 32'hD4400000
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_reset,
    input  logic [N-1:0]        cpu_pc,
    input  logic [31:0]         cpu_instr,
    output logic [31:0]         cycle_count,
    output logic [N-1:0]        halt_pc,
    output logic                done,
    output logic                overflow
);

    typedef enum logic [2:0] {
        StHdrLo,
        StHdrHi,
        StLoad,
        StFlush,
        StRun,
        StDone
    } state_e;

    localparam logic [16:0] Capacity = 17'(1) << ADDR_W;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [23:0]       word_q, word_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_waddr_q, im_waddr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic [31:0]       cycle_q, cycle_d;
    logic [N-1:0]      halt_pc_q, halt_pc_d;
    logic              overflow_q, overflow_d;

    logic        accept;
    logic [15:0] word_idx_inc;
    logic [31:0] cycle_inc;

    assign bus.rx_ready = (state_q == StHdrLo) || (state_q == StHdrHi) || (state_q == StLoad);
    assign accept       = bus.rx_valid && bus.rx_ready;
    assign word_idx_inc = word_idx_q + 16'd1;
    assign cycle_inc    = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        word_d     = word_q;
        im_we_d    = 1'b0;
        im_waddr_d = im_waddr_q;
        im_wdata_d = im_wdata_q;
        cycle_d    = cycle_q;
        halt_pc_d  = halt_pc_q;
        overflow_d = overflow_q;

        unique case (state_q)
            StHdrLo: begin
                if (accept) begin
                    len_d[7:0] = bus.rx_data;
                    state_d    = StHdrHi;
                end
            end
            StHdrHi: begin
                if (accept) begin
                    len_d[15:8] = bus.rx_data;
                    byte_idx_d  = 2'd0;
                    word_idx_d  = 16'd0;
                    state_d     = ({bus.rx_data, len_q[7:0]} == 16'd0) ? StRun : StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = bus.rx_data;
                        2'd1: word_d[15:8]  = bus.rx_data;
                        2'd2: word_d[23:16] = bus.rx_data;
                        default: begin
                            im_wdata_d = {bus.rx_data, word_q};
                            im_waddr_d = word_idx_q[ADDR_W-1:0];
                            // Words past capacity are swallowed so the stream stays in sync.
                            if ({1'b0, word_idx_q} < Capacity) begin
                                im_we_d = 1'b1;
                            end else begin
                                overflow_d = 1'b1;
                            end
                            word_idx_d = word_idx_inc;
                            if (word_idx_inc == len_q) begin
                                state_d = StFlush;
                            end
                        end
                    endcase
                end
            end
            StFlush: begin
                // Lets the final write land before the core's first fetch.
                state_d = StRun;
            end
            StRun: begin
                cycle_d = cycle_inc;
                if (cpu_instr == HALT_INSTR) begin
                    halt_pc_d = cpu_pc;
                    state_d   = StDone;
                end
            end
            StDone: begin
            end
            default: state_d = StHdrLo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StHdrLo;
            len_q      <= 16'd0;
            byte_idx_q <= 2'd0;
            word_idx_q <= 16'd0;
            word_q     <= 24'd0;
            im_we_q    <= 1'b0;
            im_waddr_q <= '0;
            im_wdata_q <= 32'd0;
            cycle_q    <= 32'd0;
            halt_pc_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            word_q     <= word_d;
            im_we_q    <= im_we_d;
            im_waddr_q <= im_waddr_d;
            im_wdata_q <= im_wdata_d;
            cycle_q    <= cycle_d;
            halt_pc_q  <= halt_pc_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.im_we    = im_we_q;
    assign bus.im_waddr = im_waddr_q;
    assign bus.im_wdata = im_wdata_q;
    assign cpu_reset    = (state_q != StRun);
    assign done         = (state_q == StDone);
    assign cycle_count  = cycle_q;
    assign halt_pc      = halt_pc_q;
    assign overflow     = overflow_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot sequencer for the 64-bit single-cycle core. While it holds the core in reset, it receives a program as a byte stream over a valid/ready interface. It assembles the bytes into 32-bit little-endian instruction words and writes them to instruction memory starting at word 0. It then releases the core, counts execution cycles until a halt instruction is fetched, and parks the core in reset.

Parameters:
N, 64, width of the core PC / instruction-memory byte address (cpu_pc, halt_pc)
ADDR_W, 6, instruction-memory word-address width; capacity 2^ADDR_W words
HALT_INSTR, 32'hD4400000, instruction encoding that ends a run

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
rx_data  in  8  program byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader accepts byte this cycle
im_we  out  1  instruction-memory write strobe
im_waddr  out  ADDR_W  instruction-memory word address
im_wdata  out  32  instruction word
cpu_reset  out  1  reset to core datapath/fetch, active-high
cpu_pc  in  N  core fetch byte address
cpu_instr  in  32  instruction currently read from instruction memory
cycle_count  out  32  RUN cycles, saturating
halt_pc  out  N  cpu_pc captured at halt
done  out  1  halted
overflow  out  1  sticky: program exceeded memory capacity

Behaviour:
- All state is registered and updates on the rising clk edge. The synchronous reset has priority over every other input.
- Reset values: state=HDR_LO, im_we=0, im_waddr=0, im_wdata=0, cycle_count=0, halt_pc=0, overflow=0, byte index=0, word index=0, L=0.
- Decoded outputs: cpu_reset=1 in every state except RUN; rx_ready=1 only in HDR_LO, HDR_HI, LOAD; done=1 only in DONE.
- A byte is accepted on an edge where rx_valid&&rx_ready. rx_data is ignored otherwise. Bubbles are allowed anywhere.
- HDR_LO: accept byte -> L[7:0], go to HDR_HI.
- HDR_HI: accept byte -> L[15:8].
  - If L==0, go straight to RUN.
  - Otherwise go to LOAD.
- LOAD: accepted bytes fill word bytes 0..3, little-endian (first byte = bits 7:0).
  - On the edge that accepts byte 3, register im_wdata=word and im_waddr=word index[ADDR_W-1:0].
  - On that same edge, set im_we=1 for exactly one cycle, but only if word index < 2^ADDR_W.
  - If word index >= 2^ADDR_W, the word is consumed with im_we=0 and overflow is set sticky.
  - The word index then increments (16-bit).
  - If the incremented index == L, go to FLUSH; otherwise stay in LOAD.
- FLUSH: one cycle, rx_ready=0, last im_we is visible here. Go to RUN on the next edge.
- cpu_reset therefore falls on the second edge after the last byte is accepted, so the final write is complete before the first fetch.
- RUN: cycle_count increments every cycle, saturating at 32'hFFFFFFFF.
  - If cpu_instr==HALT_INSTR, on that edge: halt_pc<=cpu_pc, cycle_count<=cycle_count+1 (the halt cycle is counted), go to DONE.
  - The first RUN cycle fetches PC 0.
- DONE: cpu_reset=1, outputs frozen until reset. The rx stream is ignored (rx_ready=0).
- im_we is 0 in every state except the single pulse cycle described above.
- Reset mid-load: return to HDR_LO and discard the partial word and L. Memory contents already written are not cleared; the next load starts again at im_waddr 0.
- Reset in RUN or DONE: the core is re-held in reset and the loader waits for a new header.

Test Plan:
1. Basic load and halt. Send bytes 02 00 78 56 34 12 00 00 40 D4 back-to-back.
   - Expect im_we pulses (addr 0, 32'h12345678) and (addr 1, 32'hD4400000).
   - Expect cpu_reset=0 from the second edge after the last byte.
   - Bench model returns the memory word for cpu_pc/4, with PC advancing by 4 per cycle.
   - Expect done=1, halt_pc=4, cycle_count=2.
2. Bubbles. Same bytes as scenario 1 with rx_valid deasserted 3 cycles between each byte, including mid-header.
   - Expect identical writes and identical final values.
3. Empty program. Send 00 00.
   - Expect no im_we; cpu_reset falls on the edge after the HDR_HI byte is accepted.
   - Expect rx_ready=0 and extra bytes ignored afterwards.
4. Overflow, with ADDR_W=2. Send L=5 and words 1..5.
   - Expect 4 writes at addr 0..3, none for word 5.
   - Expect overflow=1 and RUN entered after FLUSH.
5. Reset mid-load. After 02 00 and 3 bytes, assert reset for 1 cycle, then replay scenario 1.
   - Expect outputs at their reset values after reset.
   - Expect writes to start again at addr 0 with the correct words.
6. Halt on first fetch. Load 1 word of D4400000.
   - Expect done=1, halt_pc=0, cycle_count=1.
   - Expect cpu_reset=1 from DONE onward.
